// File: rtl/mem_access_seq.sv
// Memory slot sequencer: each slot is IF, DMA (round-robin over NCH channels, bounded bursts) or LS.
// *_nxt decodes are combinational from current state; rdy=0 freezes state, only request capture continues.
module mem_access_seq #(
  parameter int NCH      = 4,
  parameter int CHW      = 2,
  parameter int MAXBURST = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  input  logic           ldst_pend,
  input  logic           ls_byte,
  input  logic           ls_store,
  input  logic [NCH-1:0] dma_req,
  input  logic [NCH-1:0] zerodma,
  input  logic [NCH-1:0] dma_en,
  output logic           mem_ce,
  output logic           pipe_ce,
  output logic           pc_ce,
  output logic           selpc,
  output logic           dmapc,
  output logic [CHW-1:0] dma_ch_nxt,
  output logic           zeropc,
  output logic           word_nxt,
  output logic           read_nxt,
  output logic           dbus_nxt,
  output logic           dma,
  output logic [CHW-1:0] dma_ch,
  output logic           sync_reset
);

  localparam logic [1:0] ST_IF  = 2'd0;
  localparam logic [1:0] ST_DMA = 2'd1;
  localparam logic [1:0] ST_LS  = 2'd2;
  localparam int         BW     = 4;

  logic [1:0]     state_q, state_d;
  logic           dma_q, dma_d;
  logic [CHW-1:0] dma_ch_q, dma_ch_d;
  logic [CHW-1:0] rr_ptr_q, rr_ptr_d;
  logic [NCH-1:0] dma_pend_q, dma_pend_d;
  logic [NCH-1:0] zero_pend_q, zero_pend_d;
  logic [BW-1:0]  burst_cnt_q, burst_cnt_d;
  logic           sync_reset_q, sync_reset_d;

  logic [NCH-1:0] elig;
  logic           any_elig;
  logic [CHW-1:0] grant;
  logic [CHW:0]   cand;
  logic           found;
  logic           burst_room;
  logic [1:0]     nxt_state;
  logic           dma_nxt, ls_nxt, if_nxt;
  logic [NCH-1:0] served;

  assign elig       = dma_pend_q & dma_en;
  assign any_elig   = |elig;
  assign burst_room = burst_cnt_q < BW'(MAXBURST - 1);

  // Search rr_ptr+1 .. rr_ptr+NCH (mod NCH); with nothing eligible the grant rests on rr_ptr+1.
  always_comb begin
    grant = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = {1'b0, rr_ptr_q} + (CHW+1)'(k);
      if (cand >= (CHW+1)'(NCH)) cand = cand - (CHW+1)'(NCH);
      if (!found && (elig[cand[CHW-1:0]] || k == 1)) begin
        grant = cand[CHW-1:0];
        found = elig[cand[CHW-1:0]];
      end
    end
  end

  always_comb begin
    nxt_state = ST_IF;
    case (state_q)
      ST_IF: begin
        if (any_elig)       nxt_state = ST_DMA;
        else if (ldst_pend) nxt_state = ST_LS;
      end
      ST_DMA: begin
        if (ldst_pend)                   nxt_state = ST_LS;
        else if (any_elig && burst_room) nxt_state = ST_DMA;
      end
      default: nxt_state = ST_IF;
    endcase
  end

  assign dma_nxt = (nxt_state == ST_DMA);
  assign ls_nxt  = (nxt_state == ST_LS);
  assign if_nxt  = (nxt_state == ST_IF);

  // The channel being served drops its request when its slot completes; a new pulse on that edge survives.
  always_comb begin
    served = '0;
    if (rdy && dma_q) served[dma_ch_q] = 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    dma_d        = dma_q;
    dma_ch_d     = dma_ch_q;
    rr_ptr_d     = rr_ptr_q;
    burst_cnt_d  = burst_cnt_q;
    sync_reset_d = sync_reset_q;
    dma_pend_d   = (dma_pend_q & ~served) | dma_req;
    zero_pend_d  = (zero_pend_q & ~served) | zerodma;
    if (rdy) begin
      state_d      = nxt_state;
      dma_d        = dma_nxt;
      sync_reset_d = 1'b0;
      if (dma_nxt) begin
        rr_ptr_d    = grant;
        dma_ch_d    = grant;
        burst_cnt_d = (state_q == ST_DMA) ? burst_cnt_q + BW'(1) : '0;
      end else begin
        burst_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IF;
      dma_q        <= 1'b0;
      dma_ch_q     <= '0;
      rr_ptr_q     <= CHW'(NCH - 1);
      dma_pend_q   <= '0;
      zero_pend_q  <= '0;
      burst_cnt_q  <= '0;
      sync_reset_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      dma_q        <= dma_d;
      dma_ch_q     <= dma_ch_d;
      rr_ptr_q     <= rr_ptr_d;
      dma_pend_q   <= dma_pend_d;
      zero_pend_q  <= zero_pend_d;
      burst_cnt_q  <= burst_cnt_d;
      sync_reset_q <= sync_reset_d;
    end
  end

  assign mem_ce     = rdy;
  assign pipe_ce    = rdy & if_nxt;
  assign pc_ce      = rdy & (if_nxt | dma_nxt);
  assign selpc      = if_nxt | dma_nxt;
  assign dmapc      = dma_nxt;
  assign dma_ch_nxt = grant;
  assign zeropc     = (dma_nxt & zero_pend_q[grant]) | sync_reset_q;
  assign word_nxt   = ~(ls_nxt & ls_byte);
  assign read_nxt   = ~(ls_nxt & ls_store);
  assign dbus_nxt   = ls_nxt;
  assign dma        = dma_q;
  assign dma_ch     = dma_ch_q;
  assign sync_reset = sync_reset_q;

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: directed slot scenarios, a slot-level model compared every cycle,
// plus literal slot-order expectations per scenario.
module tb_mem_access_seq;
  localparam int NCH = 4, CHW = 2, MAXBURST = 2;
  localparam int K_IF = 0, K_DMA = 1, K_LS = 2;

  logic clk = 1'b0;
  logic rst, rdy, ldst_pend, ls_byte, ls_store;
  logic [NCH-1:0] dma_req, zerodma, dma_en;
  logic mem_ce, pipe_ce, pc_ce, selpc, dmapc, zeropc, word_nxt, read_nxt, dbus_nxt, dma, sync_reset;
  logic [CHW-1:0] dma_ch_nxt, dma_ch;

  int total = 0;
  int bad = 0;

  int m_kind, m_ch, m_rr, m_burst, e_nk, e_g;
  bit m_sync;
  bit [NCH-1:0] m_pend, m_zp;

  int tr_dma[16], tr_dmapc[16], tr_chn[16], tr_zeropc[16];
  int exp_t2[6] = '{-1, -1, 0, 2, -1, -1};
  int exp_t3[8] = '{-1, -1, 0, 1, -1, 2, 3, -1};
  int exp_t6[6] = '{-1, -1, 2, 2, -1, -1};

  always #5 clk = ~clk;

  mem_access_seq #(.NCH(NCH), .CHW(CHW), .MAXBURST(MAXBURST)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .ldst_pend(ldst_pend), .ls_byte(ls_byte), .ls_store(ls_store),
    .dma_req(dma_req), .zerodma(zerodma), .dma_en(dma_en),
    .mem_ce(mem_ce), .pipe_ce(pipe_ce), .pc_ce(pc_ce), .selpc(selpc), .dmapc(dmapc),
    .dma_ch_nxt(dma_ch_nxt), .zeropc(zeropc), .word_nxt(word_nxt), .read_nxt(read_nxt),
    .dbus_nxt(dbus_nxt), .dma(dma), .dma_ch(dma_ch), .sync_reset(sync_reset)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, $signed(act), $signed(expv));
    end
  endtask

  function automatic int pick(input bit [NCH-1:0] v, input int rr);
    for (int s = 1; s <= NCH; s++)
      if (v[(rr + s) % NCH]) return (rr + s) % NCH;
    return -1;
  endfunction

  task automatic model_check();
    bit [NCH-1:0] el;
    el  = m_pend & dma_en;
    e_g = pick(el, m_rr);
    if (m_kind == K_LS)      e_nk = K_IF;
    else if (m_kind == K_IF) e_nk = (e_g >= 0) ? K_DMA : (ldst_pend ? K_LS : K_IF);
    else                     e_nk = ldst_pend ? K_LS : ((e_g >= 0 && m_burst < MAXBURST - 1) ? K_DMA : K_IF);
    chk("m_mem_ce", mem_ce, rdy);
    chk("m_pipe_ce", pipe_ce, rdy && e_nk == K_IF);
    chk("m_pc_ce", pc_ce, rdy && e_nk != K_LS);
    chk("m_selpc", selpc, e_nk != K_LS);
    chk("m_dmapc", dmapc, e_nk == K_DMA);
    chk("m_zeropc", zeropc, (e_nk == K_DMA && m_zp[e_g]) || m_sync);
    chk("m_word_nxt", word_nxt, !(e_nk == K_LS && ls_byte));
    chk("m_read_nxt", read_nxt, !(e_nk == K_LS && ls_store));
    chk("m_dbus_nxt", dbus_nxt, e_nk == K_LS);
    chk("m_dma", dma, m_kind == K_DMA);
    chk("m_dma_ch", dma_ch, m_ch);
    chk("m_sync_reset", sync_reset, m_sync);
    if (e_g >= 0) chk("m_dma_ch_nxt", dma_ch_nxt, e_g);
  endtask

  task automatic model_step();
    if (rst) begin
      m_kind = K_IF; m_ch = 0; m_pend = '0; m_zp = '0; m_rr = NCH - 1; m_burst = 0; m_sync = 1'b1;
    end else begin
      if (rdy && m_kind == K_DMA) begin
        m_pend[m_ch] = 1'b0;
        m_zp[m_ch]   = 1'b0;
      end
      m_pend |= dma_req;
      m_zp   |= zerodma;
      if (rdy) begin
        m_sync = 1'b0;
        if (e_nk == K_DMA) begin
          m_burst = (m_kind == K_DMA) ? m_burst + 1 : 0;
          m_rr = e_g;
          m_ch = e_g;
        end else begin
          m_burst = 0;
        end
        m_kind = e_nk;
      end
    end
  endtask

  initial begin : model_proc
    @(posedge clk);
    model_step();
    forever begin
      @(negedge clk);
      model_check();
      @(posedge clk);
      model_step();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; dma_req = '0; zerodma = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic pulse_obs(input logic [NCH-1:0] req, input logic [NCH-1:0] zreq, input int n);
    dma_req = req;
    zerodma = zreq;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      tr_dma[i]    = dma ? int'(dma_ch) : -1;
      tr_dmapc[i]  = int'(dmapc);
      tr_chn[i]    = int'(dma_ch_nxt);
      tr_zeropc[i] = int'(zeropc);
      step();
      if (i == 0) begin
        dma_req = '0;
        zerodma = '0;
      end
    end
  endtask

  function automatic int dmapc_sum(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += tr_dmapc[i];
    return s;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n1;
    rst = 1'b1; rdy = 1'b1; ldst_pend = 1'b0; ls_byte = 1'b0; ls_store = 1'b0;
    dma_req = '0; zerodma = '0; dma_en = '1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state and idle IF slots
    @(negedge clk);
    chk("rst_sync_reset", sync_reset, 1);
    chk("rst_zeropc", zeropc, 1);
    chk("rst_dma", dma, 0);
    chk("rst_dma_ch", dma_ch, 0);
    chk("rst_dmapc", dmapc, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("idle_pipe_ce", pipe_ce, 1);
      chk("idle_sync_reset", sync_reset, 0);
      chk("idle_zeropc", zeropc, 0);
      chk("idle_dma", dma, 0);
      step();
    end

    // Two channels, one burst of two
    pulse_obs(4'b0101, 4'b0000, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("t2_slot%0d", i), tr_dma[i], exp_t2[i]);
    chk("t2_dmapc_cycles", dmapc_sum(6), 2);
    chk("t2_grant_first", tr_chn[1], 0);
    chk("t2_grant_second", tr_chn[2], 2);

    // All four channels, bursts capped at two
    do_reset();
    pulse_obs(4'b1111, 4'b0000, 8);
    for (int i = 0; i < 8; i++) chk($sformatf("t3_slot%0d", i), tr_dma[i], exp_t3[i]);
    chk("t3_dmapc_cycles", dmapc_sum(8), 4);

    // Load/store preempts a DMA burst
    dma_req = 4'b0001;
    @(negedge clk);
    step();
    dma_req = '0;
    @(negedge clk);
    chk("t4_pre_dmapc", dmapc, 1);
    step();
    ldst_pend = 1'b1; ls_byte = 1'b1; ls_store = 1'b1;
    @(negedge clk);
    chk("t4_in_dma", dma, 1);
    chk("t4_dbus_nxt", dbus_nxt, 1);
    chk("t4_word_nxt", word_nxt, 0);
    chk("t4_read_nxt", read_nxt, 0);
    chk("t4_dmapc", dmapc, 0);
    chk("t4_pc_ce", pc_ce, 0);
    step();
    @(negedge clk);
    chk("t4_ls_dma", dma, 0);
    chk("t4_after_dbus", dbus_nxt, 0);
    chk("t4_after_word", word_nxt, 1);
    chk("t4_after_read", read_nxt, 1);
    chk("t4_after_pipe_ce", pipe_ce, 1);
    step();
    ldst_pend = 1'b0; ls_byte = 1'b0; ls_store = 1'b0;

    // rdy stall during a DMA slot; new request on the completing edge survives
    do_reset();
    dma_req = 4'b0011;
    @(negedge clk);
    step();
    dma_req = '0;
    @(negedge clk);
    chk("t5_c1_dma_ch_nxt", dma_ch_nxt, 0);
    step();
    @(negedge clk);
    chk("t5_c2_dma_ch_nxt", dma_ch_nxt, 1);
    step();
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_stall_dma", dma, 1);
      chk("t5_stall_dma_ch", dma_ch, 1);
      chk("t5_stall_dmapc", dmapc, 0);
      chk("t5_stall_dma_ch_nxt", dma_ch_nxt, 1);
      chk("t5_stall_mem_ce", mem_ce, 0);
      step();
    end
    rdy = 1'b1;
    dma_req = 4'b0010;
    @(negedge clk);
    chk("t5_release_dma_ch", dma_ch, 1);
    chk("t5_release_pipe_ce", pipe_ce, 1);
    step();
    dma_req = '0;
    @(negedge clk);
    chk("t5_rereq_dma", dma, 0);
    chk("t5_rereq_dmapc", dmapc, 1);
    chk("t5_rereq_ch", dma_ch_nxt, 1);
    step();
    repeat (4) step();

    // Disabled channel, zero-address request, reset mid-burst
    do_reset();
    dma_en = 4'b1101;
    pulse_obs(4'b0110, 4'b0100, 10);
    for (int i = 0; i < 6; i++) chk($sformatf("t6_slot%0d", i), tr_dma[i], exp_t6[i]);
    chk("t6_dmapc_cycles", dmapc_sum(10), 2);
    chk("t6_grant", tr_chn[1], 2);
    chk("t6_zeropc_before_ch2", tr_zeropc[1], 1);
    chk("t6_zeropc_after", tr_zeropc[3], 0);
    n1 = 0;
    for (int i = 0; i < 10; i++) if (tr_dma[i] == 1) n1++;
    chk("t6_ch1_never_granted", n1, 0);
    dma_en = '1;
    @(negedge clk);
    chk("t6_enable_dmapc", dmapc, 1);
    chk("t6_enable_ch", dma_ch_nxt, 1);
    step();
    rst = 1'b1;
    dma_req = 4'b1111;
    @(negedge clk);
    chk("t6_midburst_dma", dma, 1);
    chk("t6_midburst_ch", dma_ch, 1);
    step();
    rst = 1'b0;
    dma_req = '0;
    @(negedge clk);
    chk("t6_post_rst_dma", dma, 0);
    chk("t6_post_rst_ch", dma_ch, 0);
    chk("t6_post_rst_sync", sync_reset, 1);
    chk("t6_post_rst_dmapc", dmapc, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      chk("t6_pend_dropped", dmapc, 0);
    end
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Parametrised successor to the xr16 memory-access sequencer.
- Schedules each memory slot as one of three kinds: instruction fetch (IF), DMA transfer (DMA) or load/store (LS).
- Serves NCH DMA channels with round-robin arbitration, per-channel enable, per-channel zero-address requests and bounded DMA bursts.
- Sits between the pipeline control and the memory/PC datapath; drives the memory clock-enable, pipeline advance and PC-mux controls.

Parameters:
- NCH, 4, number of DMA channels (1..16).
- CHW, 2, channel index width; must satisfy 2**CHW >= NCH.
- MAXBURST, 2, maximum back-to-back DMA slots before an IF slot is forced (1..15).

Ports:
- clk  in  1  global clock.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  current memory access completes this cycle.
- ldst_pend  in  1  EX stage holds a non-annulled load/store.
- ls_byte  in  1  pending load/store is byte wide.
- ls_store  in  1  pending load/store is a store.
- dma_req  in  NCH  per-channel DMA request pulse.
- zerodma  in  NCH  per-channel request to reset that channel's address to 0.
- dma_en  in  NCH  per-channel enable; a disabled channel keeps its pending bit but is never granted.
- mem_ce  out  1  memory access clock enable.
- pipe_ce  out  1  pipeline clock enable.
- pc_ce  out  1  PC register-file clock enable.
- selpc  out  1  address mux selects the next PC / DMA address.
- dmapc  out  1  next slot uses the DMA address register.
- dma_ch_nxt  out  CHW  channel number of the next DMA slot.
- zeropc  out  1  force the next address to 0.
- word_nxt  out  1  next access is word wide.
- read_nxt  out  1  next access is a read.
- dbus_nxt  out  1  next access uses the on-chip data bus.
- dma  out  1  current access is DMA.
- dma_ch  out  CHW  channel of the current DMA access.
- sync_reset  out  1  first slot after reset.

Behaviour:
- All state registers update only on rising clk edges.
- rst=1 forces the following on the next edge, overriding every other input:
  - state=IF, dma=0, dma_ch=0;
  - dma_pend and zero_pend all 0;
  - rr_ptr=NCH-1, so channel 0 is granted first;
  - burst_cnt=0;
  - sync_reset=1.
- sync_reset clears on the first edge with rdy=1.
- State holds while rdy=0. Every *_nxt output is combinational from the current state and pending bits.
- Eligible channels: elig = dma_pend & dma_en. any = |elig.
- Grant: the first eligible index searching rr_ptr+1, rr_ptr+2, ... modulo NCH. dma_ch_nxt shows the grant even when no DMA slot is selected.
- State transitions:
  - IF: any → DMA; else ldst_pend → LS; else stay IF.
  - DMA: ldst_pend → LS; else any and burst_cnt<MAXBURST-1 → DMA; else IF.
  - LS: always IF.
- Decodes: dma_nxt = next state is DMA; ls_nxt = next state is LS; if_nxt = next state is IF.
- On each edge with rdy=1 and dma_nxt=1:
  - rr_ptr ← grant, dma_ch ← grant;
  - burst_cnt ← 0 if the current state is not DMA, else burst_cnt+1.
- burst_cnt is reset to 0 on entering IF or LS.
- dma_pend[i]: set on dma_req[i]; cleared on an edge with dma=1, dma_ch=i, rdy=1. A simultaneous set wins.
- zero_pend[i]: same set/clear rules as dma_pend[i], using zerodma[i].
- Combinational outputs:
  - mem_ce=rdy;
  - pipe_ce=rdy&if_nxt;
  - pc_ce=rdy&(if_nxt|dma_nxt);
  - selpc=if_nxt|dma_nxt;
  - dmapc=dma_nxt;
  - zeropc=(dma_nxt&zero_pend[grant])|sync_reset;
  - word_nxt=~(ls_nxt&ls_byte);
  - read_nxt=~(ls_nxt&ls_store);
  - dbus_nxt=ls_nxt.
- NCH=1 with MAXBURST=1 reproduces the single-channel xr16 slot ordering.
- Reset asserted mid-transfer abandons the transfer and drops all pending requests.

Test Plan:
- Reset, then rdy=1 with no requests → sync_reset=1 and zeropc=1 for one cycle; after that state stays IF and pipe_ce=1 every cycle.
- dma_req=4'b0101 pulsed once, MAXBURST=2 → slots DMA(ch0), DMA(ch2), IF; pend bits end 0; dmapc=1 exactly two cycles.
- dma_req=4'b1111 with MAXBURST=2 → slot order IF, D0, D1, IF, D2, D3, IF; each channel granted exactly once.
- In DMA with ldst_pend=1, ls_byte=1, ls_store=1 → next slot is LS with word_nxt=0, read_nxt=0, dbus_nxt=1; the slot after is IF.
- rdy held at 0 for 3 cycles during a DMA slot → state, dma_ch and pend bits are frozen; the ch1 pend bit clears only on the rdy=1 edge. A dma_req[1] arriving on that same edge leaves the bit set.
- dma_en[1]=0 with dma_pend[1]=1 → ch1 is never granted and stays pending. zerodma[2]+dma_req[2] → zeropc=1 in the ch2 slot. rst asserted mid-burst → returns to IF with all pend bits 0.
